// File: rtl/pe_mc_ctrl.sv
`timescale 1ns/1ps
// pe_mc_ctrl
//   Multicast controller placed in front of a PE input FIFO on the clk_noc
//   domain. It parses NoC packet headers and forwards payload words to the
//   FIFO when the header tag matches the PE ID or the all-ones broadcast tag.
//   Packets that do not match are consumed and discarded.
//   Header word: tag = data[DATA_W-1 -: ID_W], len = data[LEN_W-1:0].
//   ID_W + LEN_W must not exceed DATA_W.
//
// Ports
//   clk_noc         NoC clock, all state on rising edge
//   rst_i           asynchronous active-high reset
//   cfg_we_i        load cfg_id_i into the ID register
//   cfg_id_i        new PE ID
//   bus_valid_i     bus word valid
//   bus_data_i      bus word (header or payload)
//   bus_ready_o     word accepted this cycle when valid
//   fifo_wr_en_o    push into the PE input FIFO
//   fifo_wr_data_o  FIFO write data (combinational copy of bus_data_i)
//   fifo_full_i     FIFO full, backpressures the bus while receiving
//   busy_o          packet in progress
//   pkt_acc_o       accepted packet count (wraps)
//   pkt_drop_o      discarded packet count (wraps)
module pe_mc_ctrl #(
    parameter int unsigned        DATA_W   = 16,
    parameter int unsigned        ID_W     = 5,
    parameter int unsigned        LEN_W    = 8,
    parameter logic [ID_W-1:0]    RESET_ID = '0
) (
    input  logic              clk_noc,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [ID_W-1:0]   cfg_id_i,
    input  logic              bus_valid_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_ready_o,
    output logic              fifo_wr_en_o,
    output logic [DATA_W-1:0] fifo_wr_data_o,
    input  logic              fifo_full_i,
    output logic              busy_o,
    output logic [15:0]       pkt_acc_o,
    output logic [15:0]       pkt_drop_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_SKIP
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic [15:0]       acc_q,   acc_d;
    logic [15:0]       drop_q,  drop_d;

    logic [ID_W-1:0]   hdr_tag;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_match;
    logic              ready;
    logic              xfer;

    assign hdr_tag   = bus_data_i[DATA_W-1 -: ID_W];
    assign hdr_len   = bus_data_i[LEN_W-1:0];
    // Match uses the registered ID, so a same-cycle config write only
    // affects later headers.
    assign hdr_match = (hdr_tag == id_q) || (&hdr_tag);

    // Ready is held low during reset even though the state is already IDLE.
    always_comb begin
        ready = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                ST_IDLE: ready = 1'b1;
                ST_RECV: ready = ~fifo_full_i;
                ST_SKIP: ready = 1'b1;
                default: ready = 1'b0;
            endcase
        end
    end

    assign xfer           = bus_valid_i & ready;
    assign bus_ready_o    = ready;
    assign fifo_wr_en_o   = (state_q == ST_RECV) & bus_valid_i & ~fifo_full_i;
    assign fifo_wr_data_o = bus_data_i;
    assign busy_o         = (state_q != ST_IDLE);
    assign pkt_acc_o      = acc_q;
    assign pkt_drop_o     = drop_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        id_d    = cfg_we_i ? cfg_id_i : id_q;
        acc_d   = acc_q;
        drop_d  = drop_q;
        if (xfer) begin
            unique case (state_q)
                ST_IDLE: begin
                    rem_d = hdr_len;
                    if (hdr_len == '0) begin
                        // Zero-length packet completes on the header itself.
                        if (hdr_match) acc_d  = acc_q + 16'd1;
                        else           drop_d = drop_q + 16'd1;
                    end else begin
                        state_d = hdr_match ? ST_RECV : ST_SKIP;
                    end
                end
                ST_RECV: begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        acc_d   = acc_q + 16'd1;
                    end
                end
                ST_SKIP: begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        drop_d  = drop_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_noc or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            id_q    <= RESET_ID;
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pe_mc_ctrl.sv
`timescale 1ns/1ps
module tb_pe_mc_ctrl;

    localparam logic [4:0] RST_ID = 5'd9;

    logic        clk_noc = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [4:0]  cfg_id_i;
    logic        bus_valid_i;
    logic [15:0] bus_data_i;
    logic        bus_ready_o;
    logic        fifo_wr_en_o;
    logic [15:0] fifo_wr_data_o;
    logic        fifo_full_i;
    logic        busy_o;
    logic [15:0] pkt_acc_o;
    logic [15:0] pkt_drop_o;

    int tests = 0;
    int fails = 0;

    // Reference: PE ID and packet counters tracked at packet granularity.
    logic [4:0] ref_id;
    int         ref_acc;
    int         ref_drop;

    pe_mc_ctrl #(
        .DATA_W   (16),
        .ID_W     (5),
        .LEN_W    (8),
        .RESET_ID (RST_ID)
    ) dut (
        .clk_noc        (clk_noc),
        .rst_i          (rst_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_id_i       (cfg_id_i),
        .bus_valid_i    (bus_valid_i),
        .bus_data_i     (bus_data_i),
        .bus_ready_o    (bus_ready_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_full_i    (fifo_full_i),
        .busy_o         (busy_o),
        .pkt_acc_o      (pkt_acc_o),
        .pkt_drop_o     (pkt_drop_o)
    );

    always #5 clk_noc = ~clk_noc;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_noc);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_acc"},  32'(pkt_acc_o),  32'(ref_acc  & 16'hFFFF));
        chk({tag, "_drop"}, 32'(pkt_drop_o), 32'(ref_drop & 16'hFFFF));
    endtask

    task automatic do_cfg(input logic [4:0] id);
        bus_valid_i = 1'b0;
        cfg_we_i    = 1'b1;
        cfg_id_i    = id;
        tick();
        cfg_we_i    = 1'b0;
        ref_id      = id;
    endtask

    // One packet. base>=0 gives payload base+i, else random payload.
    // cfg_at: word index (0 = header) carrying a config write, -1 none.
    // abort_after: return after that many payload words without finishing.
    task automatic send_pkt(input logic [4:0] tag, input int len, input int base,
                            input int full_pct, input int gap_pct, input int cfg_at,
                            input logic [4:0] cfg_val, input int abort_after);
        logic        match;
        logic [15:0] w;
        int          stalls;
        if (int'($urandom_range(99)) < gap_pct) begin
            bus_valid_i = 1'b0;
            fifo_full_i = 1'($urandom_range(1));
            #1;
            chk("idle_ready", 32'(bus_ready_o), 32'd1);
            chk("idle_wr",    32'(fifo_wr_en_o), 32'd0);
            chk("idle_busy",  32'(busy_o), 32'd0);
            tick();
        end
        match       = (tag == ref_id) || (tag == 5'h1F);
        bus_valid_i = 1'b1;
        bus_data_i  = {tag, 3'($urandom), 8'(len)};
        fifo_full_i = 1'($urandom_range(1));
        cfg_we_i    = (cfg_at == 0);
        cfg_id_i    = cfg_val;
        #1;
        chk("hdr_ready", 32'(bus_ready_o), 32'd1);
        chk("hdr_wr",    32'(fifo_wr_en_o), 32'd0);
        chk("hdr_busy",  32'(busy_o), 32'd0);
        tick();
        cfg_we_i = 1'b0;
        if (cfg_at == 0) ref_id = cfg_val;
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) return;
            w = (base >= 0) ? 16'(base + i) : 16'($urandom);
            if (int'($urandom_range(99)) < gap_pct) begin
                bus_valid_i = 1'b0;
                fifo_full_i = 1'($urandom_range(1));
                bus_data_i  = 16'($urandom);
                #1;
                chk("gap_ready", 32'(bus_ready_o), match ? 32'(!fifo_full_i) : 32'd1);
                chk("gap_wr",    32'(fifo_wr_en_o), 32'd0);
                chk("gap_busy",  32'(busy_o), 32'd1);
                tick();
            end
            stalls = (int'($urandom_range(99)) < full_pct) ? int'($urandom_range(1, 3)) : 0;
            for (int s = 0; s < stalls; s++) begin
                bus_valid_i = 1'b1;
                bus_data_i  = w;
                fifo_full_i = 1'b1;
                #1;
                chk("stall_ready", 32'(bus_ready_o), match ? 32'd0 : 32'd1);
                chk("stall_wr",    32'(fifo_wr_en_o), 32'd0);
                chk("stall_busy",  32'(busy_o), 32'd1);
                tick();
                // A dropped word is consumed even with the FIFO full.
                if (!match) break;
            end
            if (!match && stalls > 0) continue;
            bus_valid_i = 1'b1;
            bus_data_i  = w;
            fifo_full_i = 1'b0;
            cfg_we_i    = (cfg_at == i + 1);
            cfg_id_i    = cfg_val;
            #1;
            chk("pl_ready", 32'(bus_ready_o), 32'd1);
            chk("pl_wr",    32'(fifo_wr_en_o), 32'(match));
            chk("pl_data",  32'(fifo_wr_data_o), 32'(w));
            chk("pl_busy",  32'(busy_o), 32'd1);
            tick();
            cfg_we_i = 1'b0;
            if (cfg_at == i + 1) ref_id = cfg_val;
        end
        if (match) ref_acc++;
        else       ref_drop++;
        bus_valid_i = 1'b0;
        fifo_full_i = 1'b0;
        #1;
        chk("end_busy", 32'(busy_o), 32'd0);
        chk_counters("end");
    endtask

    function automatic logic [4:0] pick_tag();
        case ($urandom_range(2))
            0:       return ref_id;
            1:       return 5'h1F;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        rst_i       = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_id_i    = '0;
        bus_valid_i = 1'b1;
        bus_data_i  = 16'h1805;
        fifo_full_i = 1'b0;
        ref_id      = RST_ID;
        ref_acc     = 0;
        ref_drop    = 0;
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(bus_ready_o), 32'd0);
        chk("rst_wr",    32'(fifo_wr_en_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk_counters("rst");
        tick();
        rst_i       = 1'b0;
        bus_valid_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus_ready_o), 32'd1);
        tick();

        // Reset ID accepted before any config.
        send_pkt(RST_ID, 2, -1, 0, 0, -1, 5'd0, -1);
        do_cfg(5'd3);
        // Unicast match, then mismatch.
        send_pkt(5'd3, 4, 16'hA1, 0, 0, -1, 5'd0, -1);
        send_pkt(5'd5, 3, -1, 50, 0, -1, 5'd0, -1);
        // Broadcast then zero-length.
        send_pkt(5'h1F, 2, -1, 0, 0, -1, 5'd0, -1);
        send_pkt(5'd3, 0, -1, 0, 0, -1, 5'd0, -1);
        send_pkt(5'd4, 0, -1, 0, 0, -1, 5'd0, -1);
        // Backpressure.
        send_pkt(5'd3, 5, 16'h50, 100, 0, -1, 5'd0, -1);
        // Config mid-packet, then old and new tags.
        send_pkt(5'd3, 4, -1, 0, 0, 2, 5'd7, -1);
        send_pkt(5'd3, 2, -1, 0, 0, -1, 5'd0, -1);
        send_pkt(5'd7, 2, -1, 0, 0, -1, 5'd0, -1);
        // Config coinciding with header: header uses the old ID.
        send_pkt(5'd7, 2, -1, 0, 0, 0, 5'd12, -1);
        send_pkt(5'd7, 1, -1, 0, 0, -1, 5'd0, -1);
        send_pkt(5'd12, 1, -1, 0, 0, -1, 5'd0, -1);
        // Maximum length.
        send_pkt(5'd12, 255, -1, 10, 5, -1, 5'd0, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9) == 0) do_cfg(5'($urandom));
            send_pkt(pick_tag(), int'($urandom_range(8)), -1, 30, 30,
                     ($urandom_range(4) == 0) ? int'($urandom_range(3)) : -1,
                     5'($urandom), -1);
        end

        // Reset mid-packet after 2 of 6 payloads.
        send_pkt(ref_id, 6, -1, 0, 0, -1, 5'd0, 2);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus_ready_o), 32'd0);
        chk("mid_rst_wr",    32'(fifo_wr_en_o), 32'd0);
        chk("mid_rst_busy",  32'(busy_o), 32'd0);
        ref_acc  = 0;
        ref_drop = 0;
        ref_id   = RST_ID;
        chk_counters("mid_rst");
        tick();
        rst_i       = 1'b0;
        bus_valid_i = 1'b0;
        tick();
        send_pkt(5'd12, 1, -1, 0, 0, -1, 5'd0, -1);
        send_pkt(RST_ID, 3, -1, 20, 20, -1, 5'd0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
